// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle LEGv8 fetch/execute sequencer that selects and steps per-instruction decoders.
module control_sequencer #(
  parameter int EXEC_LIMIT = 7
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_ready,
  input  logic [31:0] mem_data,
  input  logic [3:0]  alu_status,
  input  logic [30:0] dec_control_word,
  input  logic [1:0]  dec_next_state,
  input  logic [63:0] dec_K,
  output logic [31:0] instruction,
  output logic [1:0]  state,
  output logic [3:0]  status,
  output logic [3:0]  op_class,
  output logic [30:0] control_word,
  output logic [63:0] K,
  output logic        ir_load,
  output logic        halted
);
  localparam int CW = $clog2(EXEC_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(EXEC_LIMIT);
  localparam logic [30:0] NOP_WORD = 31'h1FFFC000;
  localparam logic [30:0] FETCH_WORD = 31'h1FFFC040;
  typedef enum logic [1:0] {FETCH, EXEC, HALT} fsm_t;
  fsm_t fsm;
  logic [3:0] flag_reg;
  logic [CW-1:0] exec_count;
  logic set_flags;
  logic [10:0] opc;
  logic active;
  assign opc = instruction[31:21];
  always_comb begin
    op_class = (opc == 11'b11111000010 || opc == 11'b11111000000) ? 4'd3 :
               opc == 11'b11010110000                             ? 4'd8 :
               instruction[31:24] == 8'b01010100                  ? 4'd5 :
               instruction[30:25] == 6'b011010                    ? 4'd6 :
               instruction[30:26] == 5'b00101                     ? 4'd4 :
               ((instruction[28:24] == 5'b01010 || instruction[28:24] == 5'b01011) && !instruction[21]) ? 4'd1 :
               (instruction[28:24] == 5'b10001 || instruction[28:24] == 5'b10010) ? 4'd2 :
               instruction[28:23] == 6'b100101                    ? 4'd7 : 4'd0;
  end
  assign set_flags = (op_class == 4'd1 || op_class == 4'd2) && instruction[29];
  assign active = fsm == EXEC && op_class != 4'd0;
  // CBZ compares against the live ALU result, everything else sees latched flags
  assign status = op_class == 4'd6 ? alu_status : flag_reg;
  assign control_word = fsm == FETCH ? FETCH_WORD : active ? dec_control_word : NOP_WORD;
  assign K = active ? dec_K : '0;
  assign ir_load = fsm == FETCH && mem_ready;
  always_ff @(posedge clock) begin
    if (reset) begin
      fsm <= FETCH;
      instruction <= '0;
      state <= '0;
      flag_reg <= '0;
      exec_count <= '0;
      halted <= 1'b0;
    end else begin
      case (fsm)
        FETCH: if (mem_ready) begin
          instruction <= mem_data;
          state <= '0;
          exec_count <= '0;
          fsm <= EXEC;
        end
        EXEC: if (op_class == 4'd0) begin
          fsm <= HALT;
          halted <= 1'b1;
        end else begin
          if (set_flags && state == 2'b00) flag_reg <= alu_status;
          if (dec_next_state == 2'b00) fsm <= FETCH;
          else begin
            state <= dec_next_state;
            exec_count <= exec_count == LIMIT ? exec_count : exec_count + CW'(1);
            if (exec_count == LIMIT) begin
              fsm <= HALT;
              halted <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule
